// File: rtl/xctcmsg_bus_arbiter_pkg.sv
// rtl/xctcmsg_bus_arbiter_pkg.sv - shared types for the xctcmsg message-bus arbiter
package xctcmsg_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 32;
    localparam int unsigned MSG_W  = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        DROP    = 2'd2
    } bus_arbiter_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [TAG_W-1:0]  tag;
        logic [MSG_W-1:0]  msg;
    } bus_request_t;

endpackage

// File: rtl/xctcmsg_bus_arbiter_rr_priority_picker.sv
// rtl/xctcmsg_bus_arbiter_rr_priority_picker.sv - combinational round-robin request picker
module xctcmsg_bus_arbiter_rr_priority_picker #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_any,
    output logic [PTR_W-1:0] o_grant
);

    logic [PTR_W-1:0] w_idx;

    // Scan starting at the pointer and wrapping; the first requester found wins.
    always_comb begin
        o_any   = 1'b0;
        o_grant = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PTR_W'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_idx]) begin
                o_any   = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/xctcmsg_bus_arbiter.sv
// rtl/xctcmsg_bus_arbiter.sv - round-robin scheduler delivering xctcmsg messages between harts
import xctcmsg_bus_arbiter_pkg::*;

module xctcmsg_bus_arbiter #(
    parameter  int unsigned N_HARTS    = 4,
    parameter  int unsigned DROP_CNT_W = 16,
    localparam int unsigned PTR_W      = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_HARTS-1:0]        i_snd_val,
    output logic [N_HARTS-1:0]        o_snd_ack,
    input  logic [N_HARTS*ADDR_W-1:0] i_snd_dst,
    input  logic [N_HARTS*TAG_W-1:0]  i_snd_tag,
    input  logic [N_HARTS*MSG_W-1:0]  i_snd_msg,
    input  logic [N_HARTS-1:0]        i_rcv_rdy,
    output logic [N_HARTS-1:0]        o_rcv_val,
    output logic [ADDR_W-1:0]         o_rcv_src,
    output logic [TAG_W-1:0]          o_rcv_tag,
    output logic [MSG_W-1:0]          o_rcv_msg,
    output logic [DROP_CNT_W-1:0]     o_drop_cnt,
    output logic                      o_busy
);

    bus_arbiter_state_t    r_state;
    bus_arbiter_state_t    w_next;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      r_grant;
    logic [PTR_W-1:0]      r_dst;
    logic [TAG_W-1:0]      r_tag;
    logic [MSG_W-1:0]      r_msg;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [PTR_W-1:0]      w_grant;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_any;
    logic                  w_dst_ok;
    logic                  w_rdy;
    bus_request_t          w_sel;

    xctcmsg_bus_arbiter_rr_priority_picker #(.N(N_HARTS)) u_picker (
        .i_req   (i_snd_val),
        .i_ptr   (r_rr_ptr),
        .o_any   (w_any),
        .o_grant (w_grant)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(N_HARTS); i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_sel.dst = i_snd_dst[i*ADDR_W +: ADDR_W];
                w_sel.tag = i_snd_tag[i*TAG_W +: TAG_W];
                w_sel.msg = i_snd_msg[i*MSG_W +: MSG_W];
            end
        end
    end

    // Full-width compare so huge destination ids never alias onto a real hart.
    assign w_dst_ok  = (w_sel.dst < ADDR_W'(N_HARTS));
    assign w_rdy     = i_rcv_rdy[r_dst];
    assign w_ptr_nxt = (r_grant == PTR_W'(N_HARTS - 1)) ? '0 : r_grant + PTR_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = w_dst_ok ? DELIVER : DROP;
            DELIVER: if (w_rdy) w_next = IDLE;
            DROP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_dst      <= '0;
            r_tag      <= '0;
            r_msg      <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_dst   <= w_sel.dst[PTR_W-1:0];
                        r_tag   <= w_sel.tag;
                        r_msg   <= w_sel.msg;
                    end
                end
                DELIVER: begin
                    if (w_rdy) r_rr_ptr <= w_ptr_nxt;
                end
                DROP: begin
                    r_rr_ptr <= w_ptr_nxt;
                    if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_snd_ack = '0;
        o_rcv_val = '0;
        o_rcv_src = '0;
        o_rcv_tag = '0;
        o_rcv_msg = '0;
        case (r_state)
            DELIVER: begin
                o_rcv_val[r_dst] = 1'b1;
                o_rcv_src        = ADDR_W'(r_grant);
                o_rcv_tag        = r_tag;
                o_rcv_msg        = r_msg;
                if (w_rdy) o_snd_ack[r_grant] = 1'b1;
            end
            DROP:    o_snd_ack[r_grant] = 1'b1;
            default: ;
        endcase
    end

    assign o_drop_cnt = r_drop_cnt;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_xctcmsg_bus_arbiter.sv
// tb/tb_xctcmsg_bus_arbiter.sv - scoreboard bench for the xctcmsg bus arbiter
module tb_xctcmsg_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 2;
    localparam int SAT = (1 << DW) - 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    val;
    logic [N-1:0]    rdy;
    logic [31:0]     dst [N];
    logic [31:0]     tag [N];
    logic [63:0]     msg [N];
    logic [N*32-1:0] dst_p;
    logic [N*32-1:0] tag_p;
    logic [N*64-1:0] msg_p;

    logic [N-1:0]    o_snd_ack;
    logic [N-1:0]    o_rcv_val;
    logic [31:0]     o_rcv_src;
    logic [31:0]     o_rcv_tag;
    logic [63:0]     o_rcv_msg;
    logic [DW-1:0]   o_drop_cnt;
    logic            o_busy;

    typedef struct {
        int          src;
        int          dst;
        logic [31:0] tag;
        logic [63:0] msg;
        bit          drop;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] last_ack = '0;

    int m_phase = 0;
    int m_ptr   = 0;
    int m_g     = 0;
    int m_dst   = 0;
    int m_drops = 0;

    always_comb begin
        for (int h = 0; h < N; h++) begin
            dst_p[h*32 +: 32] = dst[h];
            tag_p[h*32 +: 32] = tag[h];
            msg_p[h*64 +: 64] = msg[h];
        end
    end

    xctcmsg_bus_arbiter #(.N_HARTS(N), .DROP_CNT_W(DW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_snd_val  (val),
        .o_snd_ack  (o_snd_ack),
        .i_snd_dst  (dst_p),
        .i_snd_tag  (tag_p),
        .i_snd_msg  (msg_p),
        .i_rcv_rdy  (rdy),
        .o_rcv_val  (o_rcv_val),
        .o_rcv_src  (o_rcv_src),
        .o_rcv_tag  (o_rcv_tag),
        .o_rcv_msg  (o_rcv_msg),
        .o_drop_cnt (o_drop_cnt),
        .o_busy     (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: decides each grant from the round-robin rule with plain integers.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_phase = 0;
            m_ptr   = 0;
            m_drops = 0;
        end else if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                int h;
                h = (m_ptr + k) % N;
                if (m_phase == 0 && val[h]) begin
                    exp_t n;
                    n.src  = h;
                    n.drop = (dst[h] >= 32'(N));
                    n.dst  = n.drop ? 0 : int'(dst[h]);
                    n.tag  = tag[h];
                    n.msg  = msg[h];
                    q.push_back(n);
                    m_g     = h;
                    m_dst   = n.dst;
                    m_phase = n.drop ? 2 : 1;
                end
            end
        end else if (m_phase == 1) begin
            if (rdy[m_dst]) begin
                m_phase = 0;
                m_ptr   = (m_g + 1) % N;
            end
        end else begin
            m_phase = 0;
            m_ptr   = (m_g + 1) % N;
            if (m_drops < SAT) m_drops++;
        end
    end

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        last_ack = o_snd_ack;
        chk("busy", o_busy, m_phase != 0);
        chk("drop_cnt", o_drop_cnt, m_drops);
        chk("ack_onehot", $countones(o_snd_ack) <= 1, 1);
        if (q.size() != 0) begin
            e = q[0];
            if (e.drop) begin
                chk("drop_rcv_val", o_rcv_val, 0);
                chk("drop_ack", o_snd_ack, 1 << e.src);
                void'(q.pop_front());
            end else begin
                chk("dlv_rcv_val", o_rcv_val, 1 << e.dst);
                chk("dlv_src", o_rcv_src, e.src);
                chk("dlv_tag", o_rcv_tag, e.tag);
                chk("dlv_msg", o_rcv_msg, e.msg);
                chk("dlv_ack", o_snd_ack, rdy[e.dst] ? (1 << e.src) : 0);
                if (rdy[e.dst]) void'(q.pop_front());
            end
        end else begin
            chk("idle_rcv_val", o_rcv_val, 0);
            chk("idle_ack", o_snd_ack, 0);
            chk("idle_data", {o_rcv_src, o_rcv_tag, o_rcv_msg}, 0);
        end
    end

    // One clock step for the senders: retire acked messages, optionally start new ones.
    task automatic cycle(input bit gen);
        @(posedge clk);
        #1;
        for (int h = 0; h < N; h++) begin
            if (val[h] && last_ack[h]) val[h] = 1'b0;
            if (gen) begin
                if (!val[h] && $urandom_range(0, 2) == 0) begin
                    val[h] = 1'b1;
                    dst[h] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
                    tag[h] = $urandom;
                    msg[h] = {$urandom, $urandom};
                end
                rdy[h] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        val = '0;
        rdy = '0;
        for (int h = 0; h < N; h++) begin
            dst[h] = '0;
            tag[h] = '0;
            msg[h] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_ack", o_snd_ack, 0);
        chk("reset_rcv_val", o_rcv_val, 0);
        chk("reset_drop", o_drop_cnt, 0);

        @(posedge clk);
        #1;
        val[1] = 1'b1;
        dst[1] = 32'd2;
        tag[1] = 32'd5;
        msg[1] = 64'hCAFE;
        rdy    = '1;
        @(negedge clk);
        chk("t1_ack_before", o_snd_ack, 0);
        @(negedge clk);
        chk("t1_rcv_val", o_rcv_val, 4'b0100);
        chk("t1_ack", o_snd_ack, 4'b0010);
        chk("t1_src", o_rcv_src, 1);
        chk("t1_tag", o_rcv_tag, 5);
        chk("t1_msg", o_rcv_msg, 64'hCAFE);
        cycle(0);
        @(negedge clk);
        chk("t1_busy_after", o_busy, 0);

        for (int c = 0; c < 3000; c++) cycle(1);

        rdy = '1;
        for (int c = 0; c < 300; c++) begin
            if (val == '0 && !o_busy) break;
            cycle(0);
        end
        chk("drain_done", val, 0);
        chk("drop_saturated", o_drop_cnt, SAT);

        cycle(0);
        val[2] = 1'b1;
        dst[2] = 32'd1;
        tag[2] = 32'h1234;
        msg[2] = 64'h0123_4567_89AB_CDEF;
        rdy    = '0;
        repeat (3) cycle(0);
        @(negedge clk);
        chk("t6_held", o_rcv_val, 4'b0010);
        cycle(0);
        rst = 1'b1;
        cycle(0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", o_busy, 0);
        chk("t6_rcv_val", o_rcv_val, 0);
        chk("t6_ack", o_snd_ack, 0);
        chk("t6_drop", o_drop_cnt, 0);
        chk("t6_data", {o_rcv_src, o_rcv_tag, o_rcv_msg}, 0);
        rdy = '1;
        for (int c = 0; c < 20; c++) begin
            if (!val[2]) break;
            cycle(0);
        end
        chk("t6_reacked", val[2], 0);

        repeat (3) cycle(0);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
